sa_controller: RTL

- Sequencer for the 4x4 systolic PE grid.
- For one matrix-multiply job it does four things in order: clears the grid, loads B top-down, streams A rows with per-row skew, and flags when each column's partial sum at the bottom edge is valid.
- It drives the shared PE control lines (data_clear, en_b_shift_bottom, en_shift_right, en_shift_bottom) and emits read indices for the A/B operand buffers.
- It sits between the host command interface and the PE array.

---
 rtl/sa_controller.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sa_controller.sv
// sa_controller: job sequencer for the NxN systolic PE grid.
//
// One job: clear the grid (1 cycle), shift B in top-down (N cycles, bottom row first),
// stream A rows with a one-cycle skew per row and flag per-column result validity
// (MUL_LAT + 2N + M - 1 cycles), then pulse done. abort sends any active job through a
// single clearing cycle back to idle. Every output is a flop; next values are decoded
// from the next state, so outputs line up with the state they describe.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, m_rows       job request and A row count (latched when the job is accepted)
//   abort               cancel the active job
//   busy, done, err     job status; done/err are one-cycle pulses
//   data_clear, en_b_shift_bottom, en_shift_right, en_shift_bottom   shared PE controls
//   b_rd_en, b_row_addr B buffer read port
//   a_row_valid, a_k_idx per-row A operand valid and index (row r at [r*IDX_W +: IDX_W])
//   res_col_valid       per-column bottom-edge result valid
module sa_controller #(
  parameter int unsigned N       = 4,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned MUL_LAT = 6,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IDX_W-1:0]   m_rows,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               data_clear,
  output logic               en_b_shift_bottom,
  output logic               en_shift_right,
  output logic               en_shift_bottom,
  output logic               b_rd_en,
  output logic [IDX_W-1:0]   b_row_addr,
  output logic [N-1:0]       a_row_valid,
  output logic [N*IDX_W-1:0] a_k_idx,
  output logic [N-1:0]       res_col_valid
);

  typedef enum logic [2:0] {StIdle, StClear, StLoadB, StRun, StDone, StAbort} state_e;

  localparam logic [CNT_W-1:0] LoadLast = CNT_W'(N - 1);
  // Last RUN index is T_TOT-1 = MUL_LAT + 2N + M - 2.
  localparam logic [CNT_W-1:0] RunBase  = CNT_W'(MUL_LAT + 2 * N - 2);
  localparam logic [CNT_W-1:0] One      = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic [IDX_W-1:0] m_q, m_d;
  logic [CNT_W-1:0] run_last;

  logic               busy_d, done_d, err_d, clear_d, en_bsb_d, en_sr_d, en_sb_d, b_rd_d;
  logic [IDX_W-1:0]   b_addr_d;
  logic [N-1:0]       a_vld_d, res_vld_d;
  logic [N*IDX_W-1:0] a_k_d;

  assign run_last = RunBase + CNT_W'(m_q);

  // Next state
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    m_d     = m_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        t_d = '0;
        if (start) begin
          if (m_rows != '0) begin
            m_d     = m_rows;
            state_d = StClear;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StClear: begin
        t_d     = '0;
        state_d = abort ? StAbort : StLoadB;
      end
      StLoadB: begin
        if (abort) begin
          state_d = StAbort;
          t_d     = '0;
        end else if (t_q == LoadLast) begin
          state_d = StRun;
          t_d     = '0;
        end else begin
          t_d = t_q + One;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StAbort;
          t_d     = '0;
        end else if (t_q == run_last) begin
          state_d = StDone;
          t_d     = '0;
        end else begin
          t_d = t_q + One;
        end
      end
      default: begin
        state_d = StIdle;
        t_d     = '0;
      end
    endcase
  end

  // Output decode of the next state, registered below
  always_comb begin
    logic [CNT_W-1:0] lo, hi;
    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StDone);
    clear_d   = (state_d == StClear) || (state_d == StAbort);
    en_bsb_d  = (state_d == StLoadB);
    b_rd_d    = (state_d == StLoadB);
    b_addr_d  = (state_d == StLoadB) ? IDX_W'(LoadLast - t_d) : '0;
    en_sr_d   = (state_d == StRun);
    en_sb_d   = (state_d == StRun);
    a_vld_d   = '0;
    a_k_d     = '0;
    res_vld_d = '0;
    lo        = '0;
    hi        = '0;
    if (state_d == StRun) begin
      for (int unsigned r = 0; r < N; r++) begin
        // Row r is skewed by r cycles.
        lo = CNT_W'(r);
        hi = lo + CNT_W'(m_d) - One;
        if (t_d >= lo && t_d <= hi) begin
          a_vld_d[r]               = 1'b1;
          a_k_d[r*IDX_W +: IDX_W]  = IDX_W'(t_d - lo);
        end
      end
      for (int unsigned c = 0; c < N; c++) begin
        lo = CNT_W'(MUL_LAT + N + c);
        hi = lo + CNT_W'(m_d) - One;
        res_vld_d[c] = (t_d >= lo) && (t_d <= hi);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= StIdle;
      t_q               <= '0;
      m_q               <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      data_clear        <= 1'b0;
      en_b_shift_bottom <= 1'b0;
      en_shift_right    <= 1'b0;
      en_shift_bottom   <= 1'b0;
      b_rd_en           <= 1'b0;
      b_row_addr        <= '0;
      a_row_valid       <= '0;
      a_k_idx           <= '0;
      res_col_valid     <= '0;
    end else begin
      state_q           <= state_d;
      t_q               <= t_d;
      m_q               <= m_d;
      busy              <= busy_d;
      done              <= done_d;
      err               <= err_d;
      data_clear        <= clear_d;
      en_b_shift_bottom <= en_bsb_d;
      en_shift_right    <= en_sr_d;
      en_shift_bottom   <= en_sb_d;
      b_rd_en           <= b_rd_d;
      b_row_addr        <= b_addr_d;
      a_row_valid       <= a_vld_d;
      a_k_idx           <= a_k_d;
      res_col_valid     <= res_vld_d;
    end
  end

endmodule
